instr_encoder: RTL and testbench

Pipelined RISC-V instruction encoder, the inverse of the core's immediate extender. It takes a decoded description of an instruction (format select, opcode, register fields, funct3, and a 32-bit signed immediate) and packs it into a 32-bit I/S/B/J instruction word. It range-checks the immediate and tags each encoded word with a sequential instruction-memory address. It sits between the testbench/boot program generator and the instruction-memory write port, and sustains one word per cycle under a valid/ready handshake.

---
 rtl/instr_encoder.sv | 146 ++++++++++++++
 tb/tb_instr_encoder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Two-stage RV32 I/S/B/J instruction packer with immediate range check and sequential address tagging.
// Optional INSTR_ENC_RANGE_CHECK_EN builds the imm_err / err_count logic; otherwise both are tied to 0.
module instr_encoder #(
    parameter int                    DATA_BUS_WIDTH = 32,
    parameter int                    ADDR_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [1:0]                imm_src,
    input  logic [6:0]                opcode,
    input  logic [4:0]                rd,
    input  logic [4:0]                rs1,
    input  logic [4:0]                rs2,
    input  logic [2:0]                funct3,
    input  logic [DATA_BUS_WIDTH-1:0] imm,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_BUS_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0]     instr_addr,
    output logic                      imm_err,
    output logic [7:0]                err_count
);

    localparam logic [1:0] FMT_I = 2'b00;
    localparam logic [1:0] FMT_S = 2'b01;
    localparam logic [1:0] FMT_B = 2'b10;

    logic                      s1_valid_q, s1_valid_d;
    logic [1:0]                s1_src_q;
    logic [6:0]                s1_opcode_q;
    logic [4:0]                s1_rd_q, s1_rs1_q, s1_rs2_q;
    logic [2:0]                s1_funct3_q;
    logic [DATA_BUS_WIDTH-1:0] s1_imm_q;

    logic                      s2_valid_q, s2_valid_d;
    logic [DATA_BUS_WIDTH-1:0] instr_q;
    logic [ADDR_WIDTH-1:0]     addr_q;

    logic                      s2_adv, s1_adv, accept, handoff;
    logic [DATA_BUS_WIDTH-1:0] packed_d;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = s1_valid_q && s2_adv;
    assign in_ready = !s1_valid_q || s2_adv;
    assign accept   = in_valid && in_ready;
    assign handoff  = s2_valid_q && out_ready;

    assign s1_valid_d = accept ? 1'b1 : (s1_adv ? 1'b0 : s1_valid_q);
    assign s2_valid_d = s1_adv ? 1'b1 : (handoff ? 1'b0 : s2_valid_q);

    always_comb begin
        packed_d = '0;
        case (s1_src_q)
            FMT_I: packed_d = {s1_imm_q[11:0], s1_rs1_q, s1_funct3_q, s1_rd_q, s1_opcode_q};
            FMT_S: packed_d = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_funct3_q,
                               s1_imm_q[4:0], s1_opcode_q};
            FMT_B: packed_d = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_funct3_q,
                               s1_imm_q[4:1], s1_imm_q[11], s1_opcode_q};
            default: packed_d = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12],
                                 s1_rd_q, s1_opcode_q};
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_src_q    <= '0;
            s1_opcode_q <= '0;
            s1_rd_q     <= '0;
            s1_rs1_q    <= '0;
            s1_rs2_q    <= '0;
            s1_funct3_q <= '0;
            s1_imm_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (accept) begin
                s1_src_q    <= imm_src;
                s1_opcode_q <= opcode;
                s1_rd_q     <= rd;
                s1_rs1_q    <= rs1;
                s1_rs2_q    <= rs2;
                s1_funct3_q <= funct3;
                s1_imm_q    <= imm;
            end
        end
    end

    // instr only changes on an S1->S2 move, which cannot happen while S2 is stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            instr_q    <= '0;
            addr_q     <= BASE_ADDR;
        end else begin
            s2_valid_q <= s2_valid_d;
            if (s1_adv)
                instr_q <= packed_d;
            if (handoff)
                addr_q <= addr_q + ADDR_WIDTH'(4);
        end
    end

    assign out_valid  = s2_valid_q;
    assign instr      = instr_q;
    assign instr_addr = addr_q;

`ifdef INSTR_ENC_RANGE_CHECK_EN
    logic       chk_err;
    logic       err_q;
    logic [7:0] err_cnt_q;

    always_comb begin
        chk_err = 1'b0;
        case (s1_src_q)
            FMT_I, FMT_S: chk_err = !(&s1_imm_q[31:11] || ~|s1_imm_q[31:11]);
            FMT_B:        chk_err = !(&s1_imm_q[31:12] || ~|s1_imm_q[31:12]) || s1_imm_q[0];
            default:      chk_err = !(&s1_imm_q[31:20] || ~|s1_imm_q[31:20]) || s1_imm_q[0];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            if (s1_adv)
                err_q <= chk_err;
            if (handoff && err_q && err_cnt_q != 8'hFF)
                err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign imm_err   = err_q;
    assign err_count = err_cnt_q;
`else
    // Upper immediate bits only feed the range check
    logic unused_imm_hi;
    assign unused_imm_hi = ^s1_imm_q[31:21];
    assign imm_err       = 1'b0;
    assign err_count     = 8'd0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder; expectations adapt to INSTR_ENC_RANGE_CHECK_EN.
module tb_instr_encoder;

`ifdef INSTR_ENC_RANGE_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  imm_src = '0;
    logic [6:0]  opcode = '0;
    logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
    logic [2:0]  funct3 = '0;
    logic [31:0] imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_addr;
    logic        imm_err;
    logic [7:0]  err_count;

    int tests = 0;
    int fails = 0;

    instr_encoder #(.DATA_BUS_WIDTH(32), .ADDR_WIDTH(32), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .imm_src(imm_src), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
        .instr(instr), .instr_addr(instr_addr), .imm_err(imm_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic desc(input logic [1:0] s, input logic [6:0] op, input logic [4:0] d,
                        input logic [4:0] r1, input logic [4:0] r2, input logic [2:0] f3,
                        input logic [31:0] im);
        in_valid = 1'b1;
        imm_src  = s;
        opcode   = op;
        rd       = d;
        rs1      = r1;
        rs2      = r2;
        funct3   = f3;
        imm      = im;
    endtask

    task automatic do_reset;
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic check_word(input string tag, input logic [31:0] w, input logic [31:0] a,
                              input logic e);
        check({tag, "_vld"}, 32'(out_valid), 32'd1);
        check({tag, "_instr"}, instr, w);
        check({tag, "_addr"}, instr_addr, a);
        check({tag, "_err"}, 32'(imm_err), 32'(e & CHK));
    endtask

    initial begin
        // Reset values, sampled while reset is asserted
        #1 rst = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_instr", instr, 32'h0);
        check("rst_imm_err", 32'(imm_err), 32'd0);
        check("rst_addr", instr_addr, 32'h0);
        check("rst_err_count", 32'(err_count), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // addi x1,x0,5 single word latency
        out_ready = 1'b1;
        desc(2'b00, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);
        check("addi_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("addi_not_yet", 32'(out_valid), 32'd0);
        tick();
        check_word("addi", 32'h00500093, 32'h0, 1'b0);
        tick();
        check("addi_drained", 32'(out_valid), 32'd0);
        check("addi_addr_inc", instr_addr, 32'h4);

        // Back-to-back stream after a fresh reset
        do_reset();
        desc(2'b01, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8);
        tick();
        desc(2'b10, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFC);
        check("stream_in_ready", 32'(in_ready), 32'd1);
        tick();
        check_word("sw", 32'h0020A423, 32'h0, 1'b0);
        desc(2'b11, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'h800);
        tick();
        in_valid = 1'b0;
        check_word("beq", 32'hFE000EE3, 32'h4, 1'b0);
        tick();
        check_word("jal", 32'h001000EF, 32'h8, 1'b0);
        tick();
        check("stream_drained", 32'(out_valid), 32'd0);

        // Range checks and boundaries
        do_reset();
        desc(2'b00, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048);
        tick();
        desc(2'b10, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'd3);
        tick();
        check_word("addi2048", 32'h80000093, 32'h0, 1'b1);
        check("cnt_before", 32'(err_count), 32'd0);
        desc(2'b00, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFF_F800);
        tick();
        check_word("b_imm3", 32'h00000163, 32'h4, 1'b1);
        check("cnt_after_addi", 32'(err_count), CHK ? 32'd1 : 32'd0);
        desc(2'b11, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFFF0_0000);
        tick();
        check_word("addi_m2048", 32'h80000093, 32'h8, 1'b0);
        check("cnt_after_b", 32'(err_count), CHK ? 32'd2 : 32'd0);
        desc(2'b11, 7'h6F, 5'd5, 5'd0, 5'd0, 3'd0, 32'h0010_0000);
        tick();
        check_word("jal_min", 32'h8000006F, 32'hC, 1'b0);
        desc(2'b01, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 32'hFFFF_FFFF);
        tick();
        check_word("jal_over", 32'h800002EF, 32'h10, 1'b1);
        desc(2'b00, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2047);
        tick();
        in_valid = 1'b0;
        check_word("sw_m1", 32'hFE20AFA3, 32'h14, 1'b0);
        check("cnt_after_j", 32'(err_count), CHK ? 32'd3 : 32'd0);
        tick();
        check_word("addi_2047", 32'h7FF00093, 32'h18, 1'b0);

        // Saturation: 300 more errored words
        desc(2'b00, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048);
        for (int i = 0; i < 300; i++) tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        check("sat_drained", 32'(out_valid), 32'd0);
        check("err_sat", 32'(err_count), CHK ? 32'd255 : 32'd0);

        // Backpressure: two-entry capacity and stable outputs
        do_reset();
        out_ready = 1'b0;
        desc(2'b00, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);
        check("bp_rdy0", 32'(in_ready), 32'd1);
        tick();
        desc(2'b01, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8);
        check("bp_rdy1", 32'(in_ready), 32'd1);
        tick();
        desc(2'b11, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'h800);
        check("bp_full", 32'(in_ready), 32'd0);
        check_word("bp_hold0", 32'h00500093, 32'h0, 1'b0);
        tick();
        tick();
        check("bp_still_full", 32'(in_ready), 32'd0);
        check_word("bp_hold1", 32'h00500093, 32'h0, 1'b0);
        out_ready = 1'b1;
        #1;
        check("bp_rdy_comb", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check_word("bp_w1", 32'h0020A423, 32'h4, 1'b0);
        tick();
        check_word("bp_w2", 32'h001000EF, 32'h8, 1'b0);
        tick();
        check("bp_drained", 32'(out_valid), 32'd0);

        // Reset mid-stream with two words in flight
        desc(2'b00, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("mid_cnt_pre", 32'(err_count), CHK ? 32'd1 : 32'd0);
        out_ready = 1'b0;
        desc(2'b00, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048);
        tick();
        tick();
        in_valid = 1'b0;
        check("mid_full", 32'(in_ready), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("mid_async_vld", 32'(out_valid), 32'd0);
        check("mid_async_rdy", 32'(in_ready), 32'd1);
        check("mid_async_cnt", 32'(err_count), 32'd0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        desc(2'b00, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);
        tick();
        in_valid = 1'b0;
        tick();
        check_word("mid_after", 32'h00500093, 32'h0, 1'b0);
        check("mid_cnt_after", 32'(err_count), 32'd0);
        tick();
        check("mid_drained", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
